// File: rtl/i2c_init_sequencer.sv
// Boot-time I2C register programmer: walks a ROM table of {dev, reg, data}
// triples and issues one write per entry, with NACK retry, delays and end markers.
module i2c_init_sequencer #(
  parameter int NUM_ENTRIES = 25,
  parameter int ROM_AW      = 8,
  parameter int ROM_LAT     = 1,
  parameter int MAX_RETRIES = 3,
  parameter int DELAY_UNIT  = 50000,
  parameter bit AUTO_START  = 1'b1
) (
  input  logic              clk_ref,
  input  logic              reset,
  input  logic              go,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_q,
  output logic              i2c_start,
  output logic [7:0]        i2c_dev,
  output logic [7:0]        i2c_reg,
  output logic [7:0]        i2c_data,
  input  logic              i2c_ready,
  input  logic              i2c_done,
  input  logic              i2c_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        entry_idx
);

  localparam int DW = $clog2(255 * DELAY_UNIT + 1);
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [DW-1:0]     DELAY_C  = DW'(DELAY_UNIT);
  localparam logic [RW-1:0]     RETRY_C  = RW'(MAX_RETRIES);
  localparam logic [1:0]        LAT_LAST = 2'(ROM_LAT);
  localparam logic [7:0]        LAST_IDX = 8'(NUM_ENTRIES - 1);
  localparam logic [ROM_AW-1:0] ADDR_ONE = ROM_AW'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DELAY, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic            go_q, auto_q, trigger;
  logic [1:0]      lat_cnt, byte_sel;
  logic [RW-1:0]   retries;
  logic [DW-1:0]   delay_cnt;

  logic go_rise;
  logic lat_last;
  logic retry_ok;

  assign go_rise  = go & ~go_q;
  assign lat_last = (lat_cnt == LAT_LAST);
  assign retry_ok = (retries < RETRY_C);

  always_ff @(posedge clk_ref) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    trigger   = 1'b0;
    i2c_start = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        busy = 1'b0;
        if (go_rise || auto_q) begin
          trigger = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: if (lat_last && (byte_sel == 2'd2)) state_d = S_DECODE;
      S_DECODE: begin
        if (i2c_dev == 8'hFF)      state_d = S_DONE;
        else if (i2c_dev == 8'hFE) state_d = (i2c_data == 8'h00) ? S_NEXT : S_DELAY;
        else                       state_d = S_ISSUE;
      end
      // A reset in this cycle must not leak a start onto the bus.
      S_ISSUE: begin
        if (i2c_ready) begin
          i2c_start = ~reset;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i2c_done) begin
          if (!i2c_nack)     state_d = S_NEXT;
          else if (retry_ok) state_d = S_ISSUE;
          else               state_d = S_ERROR;
        end
      end
      S_DELAY: if (delay_cnt <= DW'(1)) state_d = S_NEXT;
      S_NEXT:  state_d = (entry_idx == LAST_IDX) ? S_DONE : S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // rom_addr advances after every captured byte, so it already points at the
  // next entry once a fetch completes.
  always_ff @(posedge clk_ref) begin
    if (reset) begin
      go_q      <= 1'b0;
      auto_q    <= AUTO_START;
      rom_addr  <= '0;
      lat_cnt   <= '0;
      byte_sel  <= '0;
      i2c_dev   <= '0;
      i2c_reg   <= '0;
      i2c_data  <= '0;
      retries   <= '0;
      delay_cnt <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      entry_idx <= '0;
    end else begin
      go_q   <= go;
      auto_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (trigger) begin
            done      <= 1'b0;
            error     <= 1'b0;
            entry_idx <= '0;
            rom_addr  <= '0;
            lat_cnt   <= '0;
            byte_sel  <= '0;
          end
        end
        S_FETCH: begin
          if (lat_last) begin
            lat_cnt  <= '0;
            rom_addr <= rom_addr + ADDR_ONE;
            case (byte_sel)
              2'd0:    i2c_dev  <= rom_q;
              2'd1:    i2c_reg  <= rom_q;
              default: i2c_data <= rom_q;
            endcase
            byte_sel <= (byte_sel == 2'd2) ? 2'd0 : byte_sel + 2'd1;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_DECODE: begin
          retries <= '0;
          if (i2c_dev == 8'hFE) delay_cnt <= DW'(i2c_data) * DELAY_C;
        end
        S_WAIT: begin
          if (i2c_done && i2c_nack && retry_ok) retries <= retries + RW'(1);
        end
        S_DELAY: delay_cnt <= delay_cnt - DW'(1);
        S_NEXT:  entry_idx <= entry_idx + 8'd1;
        default: ;
      endcase
      if ((state_d == S_DONE) && (state_q != S_DONE))   done  <= 1'b1;
      if ((state_d == S_ERROR) && (state_q != S_ERROR)) error <= 1'b1;
    end
  end

endmodule
